// File: rtl/uart_tx_pkg.sv
// Frame definitions shared by the UART transmit and receive paths.
// Both ends decode the same 8-bit, LSB-first, one-stop-bit frame.
package uart_defs;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Even parity is the plain XOR of the byte; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter queue.
interface uart_tx_if;
  logic       i_tx_valid;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready;

  modport master (output i_tx_valid, output i_tx_byte, input o_tx_ready);
  modport slave  (input i_tx_valid, input i_tx_byte, output o_tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte queue for the UART transmitter.
// Pointers carry one extra wrap bit so full and empty are told apart.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queued bytes are serialized as start, 8 data bits
// LSB first, optional parity, and one stop bit.
module uart_tx
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_tx_if.slave                    tx,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          cnt_last;
  logic          push;
  logic          pop;
  logic          done_c;
  logic          done_p;
  logic          line_c;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;

  assign push          = tx.i_tx_valid & tx.o_tx_ready;
  assign tx.o_tx_ready = ~fifo_full;
  assign cnt_last      = (cnt_q == CNT_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (tx.i_tx_byte),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (o_fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          par_d   = parity_bit(fifo_rdata, PARITY_ODD);
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_last) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level follows the current state; it is registered below, so the
  // line (and active/done) trail the state register by one cycle.
  always_comb begin
    line_c = LINE_IDLE;
    unique case (state_q)
      S_START:  line_c = START_BIT;
      S_DATA:   line_c = shift_q[0];
      S_PARITY: line_c = par_q;
      default:  line_c = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      o_tx_serial <= LINE_IDLE;
      o_tx_active <= 1'b0;
      done_p      <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      o_tx_serial <= line_c;
      o_tx_active <= (state_q != S_IDLE);
      done_p      <= done_c;
      o_tx_done   <= done_p;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame timing, parity, burst queueing,
// push/pop collision, asynchronous reset mid-frame and idle stability.
module tb_uart_tx;

  logic clk;
  logic rst_n;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  logic       ser0, act0, done0;
  logic       ser1, act1, done1;
  logic       ser2, act2, done2;
  logic [2:0] cnt0, cnt1, cnt2;

  int n_vec = 0;
  int n_err = 0;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clock(clk), .reset(rst_n), .tx(if0),
    .o_tx_serial(ser0), .o_tx_active(act0), .o_tx_done(done0), .o_fifo_count(cnt0));

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clock(clk), .reset(rst_n), .tx(if1),
    .o_tx_serial(ser1), .o_tx_active(act1), .o_tx_done(done1), .o_fifo_count(cnt1));

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
    .clock(clk), .reset(rst_n), .tx(if2),
    .o_tx_serial(ser2), .o_tx_active(act2), .o_tx_done(done2), .o_fifo_count(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Line receiver model for dut0 (4 clocks per bit, no parity).
  logic [7:0] rx_q[$];
  int         gap_q[$];
  logic [7:0] mon_sh;
  bit         mon_in;
  int         mon_pos;
  int         hi_run;
  int         done_cnt;
  int         max_cnt;
  bit         saw_full;
  int         bad_ready;
  int         bad_stop;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_in = 1'b0;
      hi_run = 0;
    end else begin
      if (if0.o_tx_ready !== (cnt0 < 3'd4)) bad_ready++;
      if (cnt0 == 3'd4 && !if0.o_tx_ready) saw_full = 1'b1;
      if (int'(cnt0) > max_cnt) max_cnt = int'(cnt0);
      if (done0 === 1'b1) done_cnt++;
      if (!mon_in && ser0 === 1'b0) begin
        mon_in  = 1'b1;
        mon_pos = 0;
        gap_q.push_back(hi_run);
      end
      if (mon_in) begin
        if (mon_pos >= 6 && mon_pos <= 34 && (mon_pos - 6) % 4 == 0)
          mon_sh[(mon_pos - 6) / 4] = ser0;
        if (mon_pos == 38) begin
          if (ser0 !== 1'b1) bad_stop++;
          rx_q.push_back(mon_sh);
          mon_in = 1'b0;
        end
        mon_pos++;
      end
      hi_run = (ser0 === 1'b1) ? hi_run + 1 : 0;
    end
  end

  // Called just after a negedge; returns at the negedge after the handshake edge.
  task automatic push0(input logic [7:0] b);
    bit ok;
    bit took;
    took = 1'b0;
    if0.i_tx_valid = 1'b1;
    if0.i_tx_byte  = b;
    for (int t = 0; t < 2000 && !took; t++) begin
      ok = if0.o_tx_ready;
      @(posedge clk);
      if (ok) took = 1'b1;
      @(negedge clk);
    end
    if0.i_tx_valid = 1'b0;
    if (!took) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rx(input int n);
    for (int t = 0; t < 3000 && rx_q.size() < n; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    gap_q.delete();
    max_cnt   = 0;
    saw_full  = 1'b0;
    bad_ready = 0;
    bad_stop  = 0;
  endtask

  logic s_a[50], a_a[50], d_a[50], s_b[50], a_b[50], d_b[50];
  logic [9:0]  bits10;
  logic [7:0]  bits8;
  int          cnt_a, cnt_b, cnt_d, dc, line_lo, act_hi, cnt_nz;

  initial begin
    if0.i_tx_valid = 1'b0; if0.i_tx_byte = '0;
    if1.i_tx_valid = 1'b0; if1.i_tx_byte = '0;
    if2.i_tx_valid = 1'b0; if2.i_tx_byte = '0;
    done_cnt = 0;
    clear_mon();
    rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_serial", ser0, 1'b1);
    chk("rst_active", act0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ready", if0.o_tx_ready, 1'b1);
    chk("rst_count", cnt0, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Parity 0x07 on even (dut1) and odd (dut2) instances
    if1.i_tx_valid = 1'b1; if1.i_tx_byte = 8'h07;
    if2.i_tx_valid = 1'b1; if2.i_tx_byte = 8'h07;
    @(posedge clk);
    @(negedge clk);
    if1.i_tx_valid = 1'b0;
    if2.i_tx_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      s_a[i] = ser1; a_a[i] = act1; d_a[i] = done1;
      s_b[i] = ser2; a_b[i] = act2; d_b[i] = done2;
      @(negedge clk);
    end
    cnt_a = 0; cnt_b = 0; cnt_d = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_a[i]) cnt_a++;
      if (a_b[i]) cnt_b++;
      if (d_a[i]) cnt_d++;
    end
    for (int j = 0; j < 8; j++) bits8[j] = s_a[8 + 4 * j];
    chk("par_start", s_a[4], 1'b0);
    chk("par_data", bits8, 8'h07);
    chk("par_even_bit", s_a[40], 1'b1);
    chk("par_odd_bit", s_b[40], 1'b0);
    chk("par_stop", s_a[44], 1'b1);
    chk("par_active_len", cnt_a, 44);
    chk("par_odd_active_len", cnt_b, 44);
    chk("par_done_at", d_a[46], 1'b1);
    chk("par_done_cnt", cnt_d, 1);

    // Single byte 0xA5, no parity
    push0(8'hA5);
    for (int i = 0; i < 48; i++) begin
      s_a[i] = ser0; a_a[i] = act0; d_a[i] = done0;
      if (i == 0) chk("a5_count_after_push", cnt0, 3'd1);
      if (i == 1) begin
        chk("a5_count_after_pop", cnt0, 3'd0);
        chk("a5_line_before_start", ser0, 1'b1);
        chk("a5_active_before_start", act0, 1'b0);
      end
      @(negedge clk);
    end
    cnt_a = 0; cnt_d = 0;
    for (int i = 0; i < 48; i++) begin
      if (a_a[i]) cnt_a++;
      if (d_a[i]) cnt_d++;
    end
    for (int k = 0; k < 10; k++) bits10[k] = s_a[4 + 4 * k];
    chk("a5_start_edge", {s_a[1], s_a[2], a_a[2]}, 3'b101);
    chk("a5_bits", bits10, 10'h34A);
    chk("a5_active_len", cnt_a, 40);
    chk("a5_done_at", d_a[42], 1'b1);
    chk("a5_done_cnt", cnt_d, 1);
    repeat (5) @(negedge clk);

    // Burst of 6 with valid held high into a depth-4 queue
    clear_mon();
    dc = done_cnt;
    for (int k = 0; k < 6; k++) push0(8'h30 + 8'(k));
    wait_rx(6);
    for (int k = 0; k < 6; k++)
      if (k < rx_q.size()) chk("burst_byte", rx_q[k], 8'h30 + 8'(k));
    for (int k = 1; k < 6; k++)
      if (k < gap_q.size()) chk("burst_gap", gap_q[k], 5);
    chk("burst_max_count", max_cnt, 4);
    chk("burst_ready_low_full", saw_full, 1'b1);
    chk("burst_ready_rule", bad_ready, 0);
    chk("burst_stop_bits", bad_stop, 0);
    chk("burst_done_pulses", done_cnt - dc, 6);

    // Push on the exact cycle the idle FSM pops with count = 1
    clear_mon();
    push0(8'h5A);
    push0(8'hC3);
    chk("coll_count", cnt0, 3'd1);
    wait_rx(2);
    if (rx_q.size() >= 2) begin
      chk("coll_byte0", rx_q[0], 8'h5A);
      chk("coll_byte1", rx_q[1], 8'hC3);
    end
    if (gap_q.size() >= 2) chk("coll_gap", gap_q[1], 5);

    // Asynchronous reset during data bit 3
    clear_mon();
    dc = done_cnt;
    push0(8'h00);
    repeat (19) @(negedge clk);
    chk("mid_line_low", ser0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_line", ser0, 1'b1);
    chk("mid_rst_count", cnt0, 3'd0);
    chk("mid_rst_ready", if0.o_tx_ready, 1'b1);
    chk("mid_rst_active", act0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("mid_no_done", done_cnt - dc, 0);
    chk("mid_no_frame", rx_q.size(), 0);
    push0(8'h3C);
    wait_rx(1);
    if (rx_q.size() >= 1) chk("mid_after_byte", rx_q[0], 8'h3C);

    // Idle stability
    line_lo = 0; act_hi = 0; cnt_nz = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ser0 !== 1'b1) line_lo++;
      if (act0 !== 1'b0) act_hi++;
      if (cnt0 !== 3'd0) cnt_nz++;
    end
    chk("idle_line", line_lo, 0);
    chk("idle_active", act_hi, 0);
    chk("idle_count", cnt_nz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
